// File: rtl/immediate_gen_pipe_if.sv
// Handshake bundle for immediate_gen_pipe: input beat, output beat, flush and occupancy.
interface immediate_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             IN_VALID;
  logic             IN_READY;
  logic [24:0]      IN;
  logic [2:0]       IMM_SEL;
  logic [TAG_W-1:0] IN_TAG;
  logic             FLUSH;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [XLEN-1:0]  OUT;
  logic [TAG_W-1:0] OUT_TAG;
  logic [CW-1:0]    COUNT;

  modport slave (
    input  IN_VALID, IN, IMM_SEL, IN_TAG, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, OUT, OUT_TAG, COUNT
  );

  modport master (
    output IN_VALID, IN, IMM_SEL, IN_TAG, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, OUT, OUT_TAG, COUNT
  );
endinterface

// File: rtl/immediate_gen_pipe.sv
// Elastic immediate generator: decode into stage 1, DEPTH register stages, DEPTH-cycle latency.
// Backpressure: combinational ready chain from OUT_READY to IN_READY, no skid buffer.
module immediate_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input logic                   CLK,
  input logic                   RESET,
  immediate_gen_pipe_if.slave   bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]                  valid_q, valid_d;
  logic [DEPTH-1:0][XLEN-1:0]        imm_q, imm_d;
  logic [DEPTH-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic [CW-1:0]                     count_q, count_d;
  logic [DEPTH-1:0]                  adv;
  logic                              in_hs;
  logic                              out_hs;

  function automatic logic [XLEN-1:0] decode(input logic [31:7] ins, input logic [2:0] sel);
    logic [XLEN-1:0] r;
    r = '0;
    case (sel)
      3'b000:  r = XLEN'($signed({ins[31:12], 12'b0}));
      3'b001:  r = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'b010:  r = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'b011:  r = XLEN'($signed(ins[31:20]));
      3'b100:  r = XLEN'(ins[31:20]);
      3'b101:  r = XLEN'($signed({ins[31:25], ins[11:7]}));
      3'b110:  r = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
      default: r = XLEN'(ins[19:15]);
    endcase
    return r;
  endfunction

  always_comb begin
    logic a;
    a       = bus.OUT_READY;
    adv     = '0;
    valid_d = valid_q;
    imm_d   = imm_q;
    tag_d   = tag_q;

    // A stage may move when any stage at or downstream of it has a hole.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      a      = a | ~valid_q[i];
      adv[i] = a;
    end

    if (adv[0]) begin
      valid_d[0] = bus.IN_VALID;
    end
    if (adv[0] && bus.IN_VALID && !bus.FLUSH) begin
      imm_d[0] = decode(bus.IN, bus.IMM_SEL);
      tag_d[0] = bus.IN_TAG;
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i]) begin
        valid_d[i] = valid_q[i-1];
      end
      if (adv[i] && valid_q[i-1] && !bus.FLUSH) begin
        imm_d[i] = imm_q[i-1];
        tag_d[i] = tag_q[i-1];
      end
    end

    if (bus.FLUSH) begin
      valid_d = '0;
    end
  end

  assign in_hs   = bus.IN_VALID & adv[0];
  assign out_hs  = valid_q[DEPTH-1] & bus.OUT_READY;
  assign count_d = bus.FLUSH ? '0 : count_q + CW'(in_hs) - CW'(out_hs);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      valid_q <= '0;
      imm_q   <= '0;
      tag_q   <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      tag_q   <= tag_d;
      count_q <= count_d;
    end
  end

  assign bus.IN_READY  = adv[0];
  assign bus.OUT_VALID = valid_q[DEPTH-1];
  assign bus.OUT       = imm_q[DEPTH-1];
  assign bus.OUT_TAG   = tag_q[DEPTH-1];
  assign bus.COUNT     = count_q;
endmodule

// File: doc/immediate_gen_pipe.md
# immediate_gen_pipe

Parametrised, elastic successor to the combinational immediate generator for the ID stage. It accepts `instr[31:7]` plus an immediate-select code and produces the XLEN-wide extended immediate through `DEPTH` registered stages, using valid/ready flow control, a carried tag, flush, and occupancy reporting. It supports RV32/RV64 widths and adds the CSR zero-extended-immediate (zimm) format.

## Interface
- `XLEN`, 32, datapath width; legal values 32 or 64.
- `DEPTH`, 2, number of register stages; legal range 1–4.
- `TAG_W`, 5, width of the sideband tag carried with each beat (e.g. rd index).

- `CLK`  input  1  clock; all state updates on the rising edge.
- `RESET`  input  1  synchronous, active-low reset.
- `IN_VALID`  input  1  input beat present.
- `IN_READY`  output  1  stage 1 can accept a beat this cycle.
- `IN`  input  25  `instr[31:7]`; `instr[k] = IN[k-7]`.
- `IMM_SEL`  input  3  format select.
- `IN_TAG`  input  TAG_W  sideband tag, travels with the beat.
- `FLUSH`  input  1  discard all in-flight beats.
- `OUT_VALID`  output  1  final stage holds a beat.
- `OUT_READY`  input  1  consumer accepts the beat this cycle.
- `OUT`  output  XLEN  extended immediate.
- `OUT_TAG`  output  TAG_W  tag of the beat on `OUT`.
- `COUNT`  output  clog2(DEPTH+1)  number of valid beats in flight.

## Operation
- **Format select.** Decode is combinational on the input side and is captured into stage 1. Stages 2..DEPTH are pure delay registers.
  - sext = sign-extend from the top bit to XLEN; zext = zero-extend.
  - 000 U: sext({instr[31:12], 12'b0}).
  - 001 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 I: sext(instr[31:20]).
  - 100 IU: zext(instr[31:20]).
  - 101 S: sext({instr[31:25], instr[11:7]}).
  - 110 SFT: zext(instr[24:20]) when XLEN=32; zext(instr[25:20]) when XLEN=64.
  - 111 CSR: zext(instr[19:15]).
- **Per-stage state.** Each stage i holds `valid[i]`, `imm[i]` and `tag[i]`.
- **Advance rule.**
  - `adv[DEPTH] = OUT_READY | ~valid[DEPTH]`.
  - `adv[i] = adv[i+1] | ~valid[i]`.
  - `IN_READY = adv[1]`.
  - The ready chain is combinational; there is no skid buffer.
- **Transfers.**
  - Input handshake: `IN_VALID & IN_READY`.
  - Output handshake: `OUT_VALID & OUT_READY`.
  - A stage that does not advance holds its data and tag unchanged.
- **COUNT.**
  - Increments on input handshake only.
  - Decrements on output handshake only.
  - Unchanged when both or neither occur in the same cycle.
- **FLUSH.** On the next edge, all `valid[i]` clear and COUNT becomes 0.
  - An input handshake in the same cycle is dropped.
  - An output handshake in the same cycle still completes.
  - Data registers need not be cleared.
- **Ordering.** Beats leave in acceptance order; no reordering, no duplication.

## Timing
- **Reset (RESET=0 at an edge).**
  - All `valid` = 0, all `imm`/`tag` = 0, COUNT = 0.
  - Outputs: OUT_VALID = 0, OUT = 0, OUT_TAG = 0.
  - IN_READY = 1 from the first cycle after release.
  - Reset overrides FLUSH and any handshake.
  - Reset mid-stream discards all beats.
- **Latency.** A beat accepted at edge t appears on OUT after edge t+DEPTH-1, i.e. DEPTH cycles from IN_VALID to OUT_VALID, provided downstream does not stall.
- **Throughput.** One beat per cycle when OUT_READY=1.
- **Full.** When COUNT=DEPTH and OUT_READY=0, IN_READY=0 and OUT/OUT_TAG stay stable.
- **Full with drain.** When COUNT=DEPTH and OUT_READY=1, IN_READY=1 in the same cycle, because the pipeline shifts.
- **Empty.** When COUNT=0, OUT_VALID=0; OUT holds its last value.
- **Combinational paths.** OUT_READY→IN_READY is the only combinational path; all other outputs are registered.

## Test plan
- **Reset.** Hold RESET=0 for 2 cycles with IN_VALID=1 → OUT_VALID=0, OUT=0, OUT_TAG=0, COUNT=0. After release, IN_READY=1.
- **Format sweep** (XLEN=32, DEPTH=2, OUT_READY=1, back-to-back, each result appears 2 cycles after its beat):
  - 0xFFF00093 sel I → 0xFFFFFFFF.
  - 0xFFF00093 sel IU → 0x00000FFF.
  - 0x12345037 sel U → 0x12345000.
  - 0xFF9FF06F sel J → 0xFFFFFFF8.
  - 0xFE000EE3 sel B → 0xFFFFFFFC.
  - 0xFE002E23 sel S → 0xFFFFFFFC.
  - 0x01F09093 sel SFT → 0x0000001F.
  - 0x300DD073 sel CSR → 0x0000001B.
- **Width** (XLEN=64):
  - 0x80000037 sel U → 0xFFFFFFFF80000000.
  - 0x03F09093 sel SFT → 0x3F.
  - With XLEN=32, the same 0x03F09093 sel SFT → 0x1F.
- **Backpressure** (DEPTH=2, OUT_READY=0): offer tags 1, 2, 3 → 2 accepted, then IN_READY=0 with COUNT=2 and OUT stable. Raise OUT_READY → tag 3 is accepted, and tags 1, 2, 3 exit in order with one handshake per cycle.
- **Flush** (COUNT=2): assert FLUSH with IN_VALID=1 and OUT_READY=0 → next cycle COUNT=0, OUT_VALID=0, and the offered beat never appears.
- **Simultaneous / reset mid-stream.** With COUNT=1, an input and an output handshake in the same cycle → COUNT stays 1. Assert RESET=0 while COUNT=2 → next cycle COUNT=0 and OUT=0.
